// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared widths, opcode encodings and helpers for the frame-buffer memory
// arbiter (mem_arbiter, rr_arbiter, mem_arbiter_if).
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int WBEN_W = 4;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Width of a client index; never narrower than one bit so a single-client
  // build still has a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One registered RAM access as presented on the mem_* outputs.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [WBEN_W-1:0] wben;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the client request/return bus and the single RAM port of the
// memory arbiter.
//   cli_in_*       per-client request fields, client i in slice i
//   cli_out_rtr    per-client grant (combinational)
//   cli_out_rdata  shared read-return data
//   cli_out_rvalid one-hot read-return strobe
//   mem_*          synchronous frame-buffer RAM port
// Modports:
//   slave  - the arbiter itself
//   master - the surroundings: requesting engines plus the RAM
// ---------------------------------------------------------------------------
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int N_CLIENTS = 2
);

  logic [DATA_W*N_CLIENTS-1:0] cli_in_data;
  logic [ADDR_W*N_CLIENTS-1:0] cli_in_addr;
  logic [WBEN_W*N_CLIENTS-1:0] cli_in_wben;
  logic [N_CLIENTS-1:0]        cli_in_op;
  logic [N_CLIENTS-1:0]        cli_in_rts;
  logic [N_CLIENTS-1:0]        cli_out_rtr;
  logic [DATA_W-1:0]           cli_out_rdata;
  logic [N_CLIENTS-1:0]        cli_out_rvalid;

  logic              mem_ready;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [WBEN_W-1:0] mem_wben;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cli_in_data, cli_in_addr, cli_in_wben, cli_in_op, cli_in_rts,
    output cli_out_rtr, cli_out_rdata, cli_out_rvalid,
    input  mem_ready, mem_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wben
  );

  modport master (
    output cli_in_data, cli_in_addr, cli_in_wben, cli_in_op, cli_in_rts,
    input  cli_out_rtr, cli_out_rdata, cli_out_rvalid,
    output mem_ready, mem_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wben
  );

endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational pointer-based arbiter: picks the first requester at
// or after ptr_i, wrapping around. Tying ptr_i to zero turns it into a
// fixed lowest-index-wins arbiter.
//   rts_i       request vector
//   ptr_i       highest-priority index this cycle
//   gnt_o       one-hot grant (all zero when no request)
//   gnt_idx_o   binary index of the granted client
//   next_ptr_o  index just after the winner (ptr_i when nothing granted)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  rts_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic [IW-1:0] next_ptr_o
);

  logic found;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise an unassigned path infers a latch.
  always_comb begin
    gnt_o      = '0;
    gnt_idx_o  = '0;
    next_ptr_o = ptr_i;
    found      = 1'b0;
    // First pass: requesters at or above the pointer.
    for (int i = 0; i < N; i++) begin
      if (!found && rts_i[i] && (i >= int'(ptr_i))) begin
        found      = 1'b1;
        gnt_o[i]   = 1'b1;
        gnt_idx_o  = IW'(i);
        next_ptr_o = (i == N - 1) ? '0 : IW'(i + 1);
      end
    end
    // Second pass covers the wrap-around below the pointer.
    for (int i = 0; i < N; i++) begin
      if (!found && rts_i[i]) begin
        found      = 1'b1;
        gnt_o[i]   = 1'b1;
        gnt_idx_o  = IW'(i);
        next_ptr_o = (i == N - 1) ? '0 : IW'(i + 1);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Grants one client request per cycle onto a single synchronous frame-buffer
// RAM port and routes read data back to the requesting client.
//   clk   system clock, posedge
//   rst_  asynchronous active-low reset
//   bus   mem_arbiter_if.slave: client request/return bus and RAM port
// Parameters:
//   N_CLIENTS  number of engines (client 0 is the fill-rect engine)
//   RD_LAT     cycles from a read mem_en to valid mem_rdata (>= 1)
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin pointer
//                  undefined -> fixed priority, lowest index wins
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_CLIENTS = 2,
  parameter int RD_LAT    = 1
) (
  input  logic          clk,
  input  logic          rst_,
  mem_arbiter_if.slave  bus
);

  localparam int IW    = idx_width(N_CLIENTS);
  // Tag travels one stage for the output register plus RD_LAT in the RAM.
  localparam int TAG_D = RD_LAT + 1;

  logic [N_CLIENTS-1:0] rts_eff;
  logic [N_CLIENTS-1:0] gnt;
  logic [IW-1:0]        gnt_idx;
  logic [IW-1:0]        arb_next_ptr;
  logic [IW-1:0]        ptr;
  logic                 xfer;
  logic                 push_rd;

  mem_req_t req_q, req_d;
  logic     en_q, en_d;

  logic [TAG_D-1:0] tag_vld_q, tag_vld_d;
  logic [IW-1:0]    tag_idx_q [TAG_D];

  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic [N_CLIENTS-1:0] rvalid_q, rvalid_d;

  // A stalled RAM port hides every request from the arbiter, so no grant
  // and no pointer movement happen that cycle.
  assign rts_eff = bus.cli_in_rts & {N_CLIENTS{bus.mem_ready}};

`ifdef MEM_ARB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;

  assign ptr_d = xfer ? arb_next_ptr : ptr_q;
  assign ptr   = ptr_q;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  logic unused_next_ptr;

  assign ptr             = '0;
  assign unused_next_ptr = ^arb_next_ptr;
`endif

  rr_arbiter #(
    .N  (N_CLIENTS),
    .IW (IW)
  ) u_rr_arbiter (
    .rts_i      (rts_eff),
    .ptr_i      (ptr),
    .gnt_o      (gnt),
    .gnt_idx_o  (gnt_idx),
    .next_ptr_o (arb_next_ptr)
  );

  assign bus.cli_out_rtr = gnt;
  assign xfer            = |gnt;

  always_comb begin
    en_d    = xfer;
    req_d   = req_q;
    push_rd = 1'b0;
    // One-hot mux of the granted client's fields into the output stage.
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (gnt[i]) begin
        req_d.we    = bus.cli_in_op[i];
        req_d.addr  = bus.cli_in_addr[i*ADDR_W +: ADDR_W];
        req_d.wdata = bus.cli_in_data[i*DATA_W +: DATA_W];
        req_d.wben  = (bus.cli_in_op[i] == OP_WRITE) ?
                      bus.cli_in_wben[i*WBEN_W +: WBEN_W] : '0;
        push_rd     = (bus.cli_in_op[i] == OP_READ);
      end
    end

    tag_vld_d = {tag_vld_q[TAG_D-2:0], push_rd};

    // The oldest tag lines up with mem_rdata: capture and strobe its owner.
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (tag_vld_q[TAG_D-1]) begin
      rdata_d = bus.mem_rdata;
      for (int i = 0; i < N_CLIENTS; i++) begin
        rvalid_d[i] = (tag_idx_q[TAG_D-1] == IW'(i));
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      en_q      <= 1'b0;
      req_q     <= '0;
      tag_vld_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= '0;
    end else begin
      en_q      <= en_d;
      req_q     <= req_d;
      tag_vld_q <= tag_vld_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // NOTE: the tag index array is left out of reset on purpose; the reset
  // valid bits qualify it, so clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    tag_idx_q[0] <= gnt_idx;
    for (int i = 1; i < TAG_D; i++) begin
      tag_idx_q[i] <= tag_idx_q[i-1];
    end
  end

  assign bus.mem_en         = en_q;
  assign bus.mem_we         = req_q.we;
  assign bus.mem_addr       = req_q.addr;
  assign bus.mem_wdata      = req_q.wdata;
  assign bus.mem_wben       = req_q.wben;
  assign bus.cli_out_rdata  = rdata_q;
  assign bus.cli_out_rvalid = rvalid_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Memory-port arbiter that sits directly downstream of the fill-rect engine and the other drawing engines. It accepts word-wide read/write requests from N clients over rts/rtr handshakes and grants one per cycle. It drives a single synchronous frame-buffer RAM port and routes read data back to the requesting client.

## Interface
- N_CLIENTS, 2: number of requesting engines; client 0 is the fill-rect engine.
- RD_LAT, 1: cycles from mem_en (read) to valid mem_rdata.
- clk  in  1  system clock; all logic on posedge.
- rst_  in  1  reset, asynchronous, active-low.
- cli_in_data  in  32*N  per-client write data, client i at [32i+31:32i].
- cli_in_addr  in  16*N  per-client word address.
- cli_in_wben  in  4*N  per-client byte write enables; bit k enables data[8k+7:8k].
- cli_in_op  in  N  per-client opcode: 1 = write, 0 = read.
- cli_in_rts  in  N  per-client request valid.
- cli_out_rtr  out  N  per-client grant; at most one bit high per cycle.
- cli_out_rdata  out  32  read return data, shared by all clients.
- cli_out_rvalid  out  N  one-hot read-return strobe.
- mem_ready  in  1  RAM port can accept an access this cycle.
- mem_en  out  1  access strobe.
- mem_we  out  1  1 = write.
- mem_addr  out  16  word address.
- mem_wdata  out  32  write data.
- mem_wben  out  4  byte enables; 0 for reads.
- mem_rdata  in  32  read data, valid RD_LAT cycles after a read mem_en.

## Operation
- Transfer to client i occurs on a posedge where cli_in_rts[i] & cli_out_rtr[i].
- cli_out_rtr is combinational from cli_in_rts, mem_ready and the priority pointer.
- cli_out_rtr is all-zero when mem_ready = 0 or no rts is asserted.
- Clients must hold data/addr/wben/op stable while rts is high and not yet granted.
- Grant selection: first requesting client at or after the pointer, wrapping modulo N_CLIENTS. After a grant to i, pointer = (i+1) mod N.
- Accepted request is registered into the output stage: mem_en=1, mem_we=op, mem_addr, mem_wdata, mem_wben (forced 0 when op=0).
- With no transfer, mem_en=0 on the next cycle; other mem_* outputs hold their values.
- Reads: the client index is pushed into a RD_LAT+1 deep tag shift register. When the tag emerges, cli_out_rdata is loaded from mem_rdata and cli_out_rvalid[tag] pulses for one cycle.
- Writes produce no return.
- Back-to-back reads from different clients return in issue order, one per cycle.
- A write and a later read to the same address: the read observes the write, because RAM order equals grant order.
- Reset mid-operation: all in-flight read tags are discarded and no rvalid is generated; pointer returns to 0.

## Timing
- Reset values: cli_out_rvalid=0, cli_out_rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wben=0, pointer=0.
- cli_out_rtr is the combinational value with pointer=0.
- Issue latency: handshake at edge t gives mem_en high during cycle t+1.
- Read latency: a read granted at edge t gives cli_out_rvalid high during cycle t+1+RD_LAT+1. With RD_LAT=1 this is 3 cycles after the handshake edge.
- Throughput: one access per cycle while mem_ready=1.
- A single continuous requester is granted every cycle.
- mem_ready sampled low gives no grant that cycle. In-flight reads still complete; mem_ready does not stall the return path.

## Configuration
- MEM_ARB_RR_EN defined: round-robin pointer as above.
- MEM_ARB_RR_EN undefined: fixed priority, the lowest-index requesting client always wins; the pointer register is not built.
- Return path and timing are identical in both builds.

## Structure
- Shared package mem_arb_pkg holds:
  - ADDR_W=16, DATA_W=32, WBEN_W=4
  - OP_READ=1'b0, OP_WRITE=1'b1
  - a clog2-based client-index width.
- One sub-module, rr_arbiter: rts vector plus pointer in, one-hot grant and next pointer out, purely combinational. mem_arbiter owns all registers.

## Test plan
- Single write: client 0 requests addr 0x0010, data 0xAABBCCDD, wben 0xF, op 1. Required: rtr[0] high the same cycle; the next cycle gives mem_en=1, mem_we=1, addr 0x0010, data 0xAABBCCDD, mem_wben 0xF; cli_out_rvalid stays 0.
- Read return: client 1 reads 0x0020 with the RAM model holding 0x12345678. Required: cli_out_rvalid=2'b10 for exactly one cycle, 3 cycles after the handshake, with rdata 0x12345678.
- Contention:
  - Both clients hold rts for 6 cycles with MEM_ARB_RR_EN defined. Required: grants alternate 0,1,0,1,0,1.
  - Same stimulus without the macro. Required: client 0 is granted all 6 cycles.
- Backpressure: mem_ready low for 3 cycles while client 0 requests. Required: rtr stays 0 and mem_en stays 0; the grant occurs in the first cycle after mem_ready returns high.
- Fill-rect stream: an 8x8 fill at address 0 with data 0x03020100 and wben 0xF. Required: 16 consecutive mem writes (64 pixels at 4 per word) with addresses matching the engine's sequence, and no dropped or duplicated word.
- Reset mid-read: rst_ asserted one cycle after a read grant. Required: all outputs return to reset values asynchronously, and no rvalid appears after release.
